cpu_seq: RTL and testbench

- Fetch/execute sequencer for the 16-bit CPU.
- Drives the 8-entry register file's selects and strobes (regr0s, regr1s, regws, we, he, incr_pc) and the memory request handshake.
- Decodes one instruction at a time from the instruction register (IR).
- Sits between the register file/ALU datapath and the memory bus. Sequences every register-file write, so PC increment and normal writes never collide.

---
 rtl/cpu_seq.sv | 226 ++++++++++++++++++++++
 tb/tb_cpu_seq.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq.sv
// -----------------------------------------------------------------------------
// cpu_seq -- fetch/execute sequencer for the 16-bit CPU
//
// Fetches one instruction at a time over the memory handshake, holds it in
// the instruction register (IR) and drives the register file selects/strobes
// for exactly one write per instruction. PC increment happens only on the
// fetch ack cycle, so it can never coincide with a normal register write.
//
// Parameters
//   TIMEOUT   cycles a memory request may stay un-acked before halting with err
//   TO_W      width of the timeout counter (must hold TIMEOUT)
//
// Ports
//   clk        in   system clock, state updates on posedge
//   reset      in   asynchronous active-low reset; forces all outputs to 0
//   mem_rdata  in   memory read data (instruction or load data)
//   mem_ack    in   memory completes the current request this cycle
//   alu_zero   in   register file regr0 output == 0
//   mem_req    out  memory request, held until mem_ack
//   mem_we     out  request is a store
//   regr0s     out  register file read select 0
//   regr1s     out  register file read select 1
//   regws      out  register file write select
//   we         out  register file write enable (never with regws == 0)
//   he         out  high-byte write: regw[6:0] -> R[15:9]
//   incr_pc    out  R7 += 2 strobe
//   alu_fn     out  ALU function, IR[2:0]
//   wb_sel     out  regw source: 0 ALU, 1 mem_rdata, 2 IR[6:0], 3 regr1
//   halted     out  sequencer is in HALT
//   err        out  halt caused by illegal opcode or timeout (sticky)
// -----------------------------------------------------------------------------
module cpu_seq #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    input  logic        alu_zero,
    output logic        mem_req,
    output logic        mem_we,
    output logic [2:0]  regr0s,
    output logic [2:0]  regr1s,
    output logic [2:0]  regws,
    output logic        we,
    output logic        he,
    output logic        incr_pc,
    output logic [2:0]  alu_fn,
    output logic [1:0]  wb_sel,
    output logic        halted,
    output logic        err
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_HALT  = 2'd3
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ALU  = 4'h1;
    localparam logic [3:0] OP_LDW  = 4'h2;
    localparam logic [3:0] OP_STW  = 4'h3;
    localparam logic [3:0] OP_LDH  = 4'h4;
    localparam logic [3:0] OP_BEQZ = 4'h5;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_IMM = 2'd2;
    localparam logic [1:0] WB_R1  = 2'd3;

    state_t          state;
    logic [15:0]     ir;
    logic [TO_W-1:0] to_cnt;
    logic            err_q;

    // Instruction fields of the held instruction.
    logic [3:0] op;
    logic [2:0] rd;
    logic [2:0] rs1;
    logic [2:0] rs2;

    assign op  = ir[15:12];
    assign rd  = ir[11:9];
    assign rs1 = ir[8:6];
    assign rs2 = ir[5:3];

    // A bus request is outstanding in FETCH and MEM; used for timeout counting.
    logic req_active;
    logic timeout_hit;

    assign req_active  = (state == S_FETCH) || (state == S_MEM);
    // The request has already been un-acked for TIMEOUT-1 cycles; if this
    // cycle also goes un-acked, the limit is reached and we halt.
    assign timeout_hit = (to_cnt == TO_W'(TIMEOUT - 1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= S_FETCH;
            ir     <= '0;
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            // Clearing whenever no request is waiting covers both state entry
            // (EXEC/ack cycles have no waiting request) and the ack itself.
            if (req_active && !mem_ack)
                to_cnt <= to_cnt + TO_W'(1);
            else
                to_cnt <= '0;

            unique case (state)
                S_FETCH: begin
                    if (mem_ack) begin
                        ir <= mem_rdata;
                        // Decode straight from the bus: IR is loaded on this edge.
                        case (mem_rdata[15:12])
                            OP_NOP:                    state <= S_FETCH;
                            OP_ALU, OP_LDH, OP_BEQZ:   state <= S_EXEC;
                            OP_LDW, OP_STW:            state <= S_MEM;
                            OP_HALT:                   state <= S_HALT;
                            default: begin
                                state <= S_HALT;
                                err_q <= 1'b1;
                            end
                        endcase
                    end else if (timeout_hit) begin
                        state <= S_HALT;
                        err_q <= 1'b1;
                    end
                end
                S_EXEC: state <= S_FETCH;
                S_MEM: begin
                    if (mem_ack) begin
                        state <= S_FETCH;
                    end else if (timeout_hit) begin
                        state <= S_HALT;
                        err_q <= 1'b1;
                    end
                end
                S_HALT: state <= S_HALT;
                default: state <= S_HALT;
            endcase
        end
    end

    // Outputs are combinational from state, IR and mem_ack, and are gated by
    // reset so a mid-request reset drops mem_req without waiting for a clock.
    // NOTE: every output gets a default at the top of the block; without it,
    // paths that skip an assignment would infer latches.
    always_comb begin
        mem_req = 1'b0;
        mem_we  = 1'b0;
        regr0s  = 3'd0;
        regr1s  = 3'd0;
        regws   = 3'd0;
        we      = 1'b0;
        he      = 1'b0;
        incr_pc = 1'b0;
        alu_fn  = 3'd0;
        wb_sel  = WB_ALU;
        halted  = 1'b0;
        err     = 1'b0;

        if (reset) begin
            alu_fn = ir[2:0];
            err    = err_q;

            unique case (state)
                S_FETCH: begin
                    regr0s  = 3'd7;
                    mem_req = 1'b1;
                    incr_pc = mem_ack;
                end
                S_EXEC: begin
                    regr0s = (op == OP_BEQZ) ? rd  : rs1;
                    regr1s = (op == OP_BEQZ) ? rs1 : rs2;
                    case (op)
                        OP_ALU: begin
                            we     = 1'b1;
                            regws  = rd;
                            wb_sel = WB_ALU;
                        end
                        OP_LDH: begin
                            we     = 1'b1;
                            he     = 1'b1;
                            regws  = rd;
                            wb_sel = WB_IMM;
                        end
                        OP_BEQZ: begin
                            // Branch target comes from rs1 through the regr1 port.
                            we     = alu_zero;
                            regws  = 3'd7;
                            wb_sel = WB_R1;
                        end
                        default: ;
                    endcase
                end
                S_MEM: begin
                    regr0s  = rs1;
                    regr1s  = rd;
                    mem_req = 1'b1;
                    mem_we  = (op == OP_STW);
                    if (op == OP_LDW && mem_ack) begin
                        we     = 1'b1;
                        regws  = rd;
                        wb_sel = WB_MEM;
                    end
                end
                S_HALT: halted = 1'b1;
                default: ;
            endcase

            // R0 is hardwired zero: a write to it is decoded as no write.
            if (regws == 3'd0) begin
                we = 1'b0;
                he = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_seq.sv
// -----------------------------------------------------------------------------
// tb_cpu_seq -- self-checking bench for cpu_seq
//
// The driver applies inputs 1 time unit after each rising edge and pushes the
// full expected output vector for that cycle onto a scoreboard queue; the
// monitor pops and compares on the following falling edge. Reset behaviour is
// checked directly between edges.
// -----------------------------------------------------------------------------
module tb_cpu_seq;

    localparam int TIMEOUT = 255;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic [2:0] regr0s;
        logic [2:0] regr1s;
        logic [2:0] regws;
        logic       we;
        logic       he;
        logic       incr_pc;
        logic [2:0] alu_fn;
        logic [1:0] wb_sel;
        logic       halted;
        logic       err;
    } outs_t;

    typedef struct {
        string tag;
        outs_t o;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;
    logic        alu_zero = 1'b0;
    logic        mem_req, mem_we, we, he, incr_pc, halted, err;
    logic [2:0]  regr0s, regr1s, regws, alu_fn;
    logic [1:0]  wb_sel;

    int    checks = 0;
    int    errors = 0;
    sb_t   sb[$];
    sb_t   mon_e;
    logic [15:0] cur_ir = '0;

    cpu_seq #(.TIMEOUT(TIMEOUT), .TO_W(8)) dut (
        .clk(clk), .reset(reset), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .alu_zero(alu_zero), .mem_req(mem_req), .mem_we(mem_we),
        .regr0s(regr0s), .regr1s(regr1s), .regws(regws), .we(we), .he(he),
        .incr_pc(incr_pc), .alu_fn(alu_fn), .wb_sel(wb_sel),
        .halted(halted), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic outs_t sample();
        outs_t s;
        s = '{mem_req, mem_we, regr0s, regr1s, regws, we, he, incr_pc,
              alu_fn, wb_sel, halted, err};
        return s;
    endfunction

    function automatic outs_t o_base(input logic [15:0] ir);
        outs_t o;
        o = '0;
        o.alu_fn = ir[2:0];
        return o;
    endfunction

    function automatic outs_t o_fetch(input logic ack, input logic [15:0] ir);
        outs_t o;
        o = o_base(ir);
        o.mem_req = 1'b1;
        o.regr0s  = 3'd7;
        o.incr_pc = ack;
        return o;
    endfunction

    function automatic outs_t o_halt(input logic e, input logic [15:0] ir);
        outs_t o;
        o = o_base(ir);
        o.halted = 1'b1;
        o.err    = e;
        return o;
    endfunction

    // Monitor: compare the scoreboard head and the write invariants each cycle.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            check(mon_e.tag, 32'(sample()), 32'(mon_e.o));
        end
        check("incr_pc_we_excl", 32'(incr_pc && we), 32'd0);
        check("no_r0_write", 32'(we && (regws == 3'd0)), 32'd0);
    end

    task automatic step(input string tag, input logic ack, input logic [15:0] rdata,
                        input logic zero, input outs_t e);
        sb_t item;
        @(posedge clk);
        #1;
        mem_ack   = ack;
        mem_rdata = rdata;
        alu_zero  = zero;
        item.tag  = tag;
        item.o    = e;
        sb.push_back(item);
    endtask

    // Fetch with `waits` un-acked cycles, then ack with new_ir.
    task automatic fetch(input logic [15:0] new_ir, input int waits);
        for (int i = 0; i < waits; i++)
            step("fetch_wait", 1'b0, 16'h0000, 1'b0, o_fetch(1'b0, cur_ir));
        step("fetch_ack", 1'b1, new_ir, 1'b0, o_fetch(1'b1, cur_ir));
        cur_ir = new_ir;
    endtask

    // Assert reset between edges, check outputs drop, release and check FETCH.
    task automatic do_reset(input string tag);
        @(negedge clk);
        #2;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        alu_zero  = 1'b0;
        reset     = 1'b0;
        #1;
        check({tag, "_zero"}, 32'(sample()), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check({tag, "_release"}, 32'(sample()), 32'(o_fetch(1'b0, 16'h0000)));
        cur_ir = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, time %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        outs_t e;

        // Phase A: main instruction mix.
        do_reset("init");

        // ALU r1 <= r1 fn r2, fn 3; ack in cycle 2.
        fetch(16'h1253, 2);
        e = o_base(cur_ir);
        e.regr0s = 3'd1; e.regr1s = 3'd2; e.regws = 3'd1; e.we = 1'b1;
        step("alu_exec", 1'b0, 16'h0000, 1'b0, e);

        // LDW r2, [r1] with three wait cycles in MEM.
        fetch(16'h2440, 0);
        e = o_base(cur_ir);
        e.mem_req = 1'b1; e.regr0s = 3'd1; e.regr1s = 3'd2;
        for (int i = 0; i < 3; i++) step("ldw_wait", 1'b0, 16'h0000, 1'b0, e);
        e.we = 1'b1; e.regws = 3'd2; e.wb_sel = 2'd1;
        step("ldw_ack", 1'b1, 16'hBEEF, 1'b0, e);

        // STW [r1], r2 with one wait cycle.
        fetch(16'h3440, 0);
        e = o_base(cur_ir);
        e.mem_req = 1'b1; e.mem_we = 1'b1; e.regr0s = 3'd1; e.regr1s = 3'd2;
        step("stw_wait", 1'b0, 16'h0000, 1'b0, e);
        step("stw_ack", 1'b1, 16'h0000, 1'b0, e);

        // LDH r5, 0x7F.
        fetch(16'h4A7F, 1);
        e = o_base(cur_ir);
        e.regr0s = 3'd1; e.regr1s = 3'd7; e.regws = 3'd5;
        e.we = 1'b1; e.he = 1'b1; e.wb_sel = 2'd2;
        step("ldh_exec", 1'b0, 16'h0000, 1'b0, e);

        // BEQZ r1, r5 taken and not taken.
        fetch(16'h5340, 0);
        e = o_base(cur_ir);
        e.regr0s = 3'd1; e.regr1s = 3'd5; e.regws = 3'd7; e.wb_sel = 2'd3;
        e.we = 1'b1;
        step("beqz_taken", 1'b0, 16'h0000, 1'b1, e);
        fetch(16'h5340, 0);
        e.we = 1'b0;
        step("beqz_not_taken", 1'b0, 16'h0000, 1'b0, e);

        // NOP goes straight back to FETCH; then an ALU op targeting R0.
        fetch(16'h0000, 0);
        fetch(16'h1053, 0);
        e = o_base(cur_ir);
        e.regr0s = 3'd1; e.regr1s = 3'd2; e.regws = 3'd0;
        step("alu_r0_exec", 1'b0, 16'h0000, 1'b0, e);

        // Illegal opcode halts with err; acks are ignored in HALT.
        fetch(16'h7000, 0);
        step("illegal_halt", 1'b1, 16'h1253, 1'b0, o_halt(1'b1, cur_ir));
        step("illegal_halt_hold", 1'b1, 16'h1253, 1'b0, o_halt(1'b1, cur_ir));

        // Phase B: reset exits HALT; HALT opcode halts without err.
        do_reset("halt_exit");
        fetch(16'hF000, 0);
        step("halt_op", 1'b0, 16'h0000, 1'b0, o_halt(1'b0, cur_ir));
        step("halt_op_hold", 1'b1, 16'h2440, 1'b0, o_halt(1'b0, cur_ir));

        // Phase C: reset asserted while a load waits in MEM.
        do_reset("pre_abort");
        fetch(16'h2440, 0);
        e = o_base(cur_ir);
        e.mem_req = 1'b1; e.regr0s = 3'd1; e.regr1s = 3'd2;
        step("abort_mem_wait", 1'b0, 16'h0000, 1'b0, e);
        step("abort_mem_wait", 1'b0, 16'h0000, 1'b0, e);
        do_reset("mid_mem");

        // Phase D: resync with a NOP, then withhold the ack until timeout.
        fetch(16'h0000, 0);
        for (int i = 0; i < TIMEOUT; i++)
            step("timeout_wait", 1'b0, 16'h0000, 1'b0, o_fetch(1'b0, cur_ir));
        step("timeout_halt", 1'b0, 16'h0000, 1'b0, o_halt(1'b1, cur_ir));
        step("timeout_halt_hold", 1'b1, 16'h1253, 1'b0, o_halt(1'b1, cur_ir));

        @(negedge clk);
        #1;
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
